// File: rtl/time_entry_pkg.sv
// Shared encodings for the stopwatch time-entry block: field select codes,
// FSM states, per-field BCD limits and the wrap-around BCD step helper.
package time_entry_pkg;

  localparam logic [1:0] FIELD_SEC100 = 2'd0;
  localparam logic [1:0] FIELD_SEC    = 2'd1;
  localparam logic [1:0] FIELD_MIN    = 2'd2;

  typedef enum logic {
    ST_EDIT = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Field maxima held directly in BCD so they compare against the digit registers.
  localparam logic [7:0] SEC100_MAX = 8'h99;
  localparam logic [7:0] SEC_MAX    = 8'h59;
  localparam logic [7:0] MIN_MAX    = 8'h99;

  function automatic logic [7:0] bcd_step(input logic [7:0] val,
                                          input logic [7:0] max_val,
                                          input logic       up);
    logic [7:0] res;
    res = val;
    if (up) begin
      if (val == max_val) res = 8'h00;
      else if (val[3:0] == 4'd9) res = {val[7:4] + 4'd1, 4'd0};
      else res = {val[7:4], val[3:0] + 4'd1};
    end else begin
      if (val == 8'h00) res = max_val;
      else if (val[3:0] == 4'd0) res = {val[7:4] - 4'd1, 4'd9};
      else res = {val[7:4], val[3:0] - 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/time_entry_btn_debounce.sv
// One pushbutton front end: 2-flop synchronizer, counting debouncer, rising-edge
// press pulse and, when enabled, hold-to-repeat steps merged into the pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_r;
  logic          sync_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          press_r;
  logic          block_r;
  logic          tick_s;

  // Synchronizer deliberately unreset so a button held through reset is seen as held.
  always_ff @(posedge clk) begin
    meta_r <= raw;
    sync_r <= meta_r;
  end

  // Debounce counter, debounced level and edge pulse; presses stay blocked after reset until a release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
      press_r <= 1'b0;
      block_r <= 1'b1;
    end else begin
      press_r <= 1'b0;
      if (!level_r && !sync_r) block_r <= 1'b0;
      if (sync_r == level_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync_r;
        cnt_r   <= CNT_ZERO;
        press_r <= sync_r & ~block_r;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  if (REPEAT_EN) begin : g_rep
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] REP_ONE  = RW'(32'd1);
    localparam logic [RW-1:0] DLY_C    = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PER_C    = RW'(REPEAT_PERIOD);

    logic [RW-1:0] rep_cnt_r;
    logic          periodic_r;
    logic          hit_s;

    // Repeat step fires when the cycle count since the last step reaches the current interval.
    always_comb begin
      hit_s = 1'b0;
      if (level_r && (rep_cnt_r != REP_ZERO)) begin
        if (periodic_r) hit_s = (rep_cnt_r == PER_C);
        else hit_s = (rep_cnt_r == DLY_C);
      end else begin
        hit_s = 1'b0;
      end
    end

    // Counter only runs after a genuine press, so a blocked level never repeats.
    always_ff @(posedge clk) begin
      if (!reset) begin
        rep_cnt_r  <= REP_ZERO;
        periodic_r <= 1'b0;
      end else if (press_r) begin
        rep_cnt_r  <= REP_ONE;
        periodic_r <= 1'b0;
      end else if (rep_cnt_r != REP_ZERO) begin
        if (!level_r) begin
          rep_cnt_r  <= REP_ZERO;
          periodic_r <= 1'b0;
        end else if (hit_s) begin
          rep_cnt_r  <= REP_ONE;
          periodic_r <= 1'b1;
        end else begin
          rep_cnt_r <= rep_cnt_r + REP_ONE;
        end
      end
    end

    assign tick_s = hit_s;
  end else begin : g_norep
    assign tick_s = 1'b0;
  end

  assign press = press_r | tick_s;

endmodule

// File: rtl/time_entry.sv
// Time-entry front panel: edits a min:sec:sec100 BCD value with debounced buttons
// and hands it off with a one-cycle load pulse, then locks until stop or clear.
module time_entry
  import time_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       increment,
  input  logic       decrement,
  input  logic       place100,
  input  logic       placeSec,
  input  logic       placeMin,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] min_10s,
  output logic [3:0] min_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] sec_1s,
  output logic [3:0] sec100_10s,
  output logic [3:0] sec100_1s,
  output logic [1:0] field,
  output logic       load,
  output logic       locked
);

  localparam int B_INC   = 0;
  localparam int B_DEC   = 1;
  localparam int B_P100  = 2;
  localparam int B_PSEC  = 3;
  localparam int B_PMIN  = 4;
  localparam int B_START = 5;
  localparam int B_STOP  = 6;
  localparam int B_CLR   = 7;

  logic [7:0] raw_s;
  logic [7:0] step_s;
  logic [7:0] cur_s;
  logic [7:0] lim_s;
  logic [7:0] next_s;
  logic       do_step_s;
  logic       any_nz_s;

  state_e     state_r;
  logic [1:0] field_r;
  logic [7:0] min_r;
  logic [7:0] sec_r;
  logic [7:0] s100_r;
  logic       load_r;
  logic       locked_r;

  assign raw_s = {clear, stop, start, placeMin, placeSec, place100, decrement, increment};

  for (genvar i = 0; i < 8; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (i < 2),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_btn (
      .clk  (clk_100MHz),
      .reset(reset),
      .raw  (raw_s[i]),
      .press(step_s[i])
    );
  end

  // One shared BCD stepper fed by whichever field is currently selected.
  always_comb begin
    cur_s = s100_r;
    lim_s = SEC100_MAX;
    case (field_r)
      FIELD_SEC: begin
        cur_s = sec_r;
        lim_s = SEC_MAX;
      end
      FIELD_MIN: begin
        cur_s = min_r;
        lim_s = MIN_MAX;
      end
      default: begin
        cur_s = s100_r;
        lim_s = SEC100_MAX;
      end
    endcase
    next_s = bcd_step(cur_s, lim_s, step_s[B_INC]);
  end

  assign do_step_s = step_s[B_INC] ^ step_s[B_DEC];
  assign any_nz_s  = |{min_r, sec_r, s100_r};

  // EDIT/HOLD state machine owning the digits, field select and registered outputs.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_r  <= ST_EDIT;
      field_r  <= FIELD_SEC100;
      min_r    <= 8'h00;
      sec_r    <= 8'h00;
      s100_r   <= 8'h00;
      load_r   <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      load_r <= 1'b0;
      if (step_s[B_CLR]) begin
        state_r  <= ST_EDIT;
        field_r  <= FIELD_SEC100;
        min_r    <= 8'h00;
        sec_r    <= 8'h00;
        s100_r   <= 8'h00;
        locked_r <= 1'b0;
      end else begin
        case (state_r)
          ST_EDIT: begin
            if (step_s[B_START] && any_nz_s) begin
              load_r   <= 1'b1;
              locked_r <= 1'b1;
              state_r  <= ST_HOLD;
            end else begin
              if (step_s[B_PMIN]) field_r <= FIELD_MIN;
              else if (step_s[B_PSEC]) field_r <= FIELD_SEC;
              else if (step_s[B_P100]) field_r <= FIELD_SEC100;
              // A step lands on the field selected before any same-cycle field change.
              if (do_step_s) begin
                case (field_r)
                  FIELD_SEC: sec_r  <= next_s;
                  FIELD_MIN: min_r  <= next_s;
                  default:   s100_r <= next_s;
                endcase
              end
            end
          end
          ST_HOLD: begin
            if (step_s[B_STOP]) begin
              state_r  <= ST_EDIT;
              locked_r <= 1'b0;
            end
          end
          default: begin
            state_r  <= ST_EDIT;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign min_10s    = min_r[7:4];
  assign min_1s     = min_r[3:0];
  assign sec_10s    = sec_r[7:4];
  assign sec_1s     = sec_r[3:0];
  assign sec100_10s = s100_r[7:4];
  assign sec100_1s  = s100_r[3:0];
  assign field      = field_r;
  assign load       = load_r;
  assign locked     = locked_r;

endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: vector table of button taps, a load scoreboard,
// and hand-written bounce, auto-repeat and reset sequences.
`timescale 1ns/1ps
module tb_time_entry;

  localparam logic [7:0] B_INC   = 8'h01;
  localparam logic [7:0] B_DEC   = 8'h02;
  localparam logic [7:0] B_P100  = 8'h04;
  localparam logic [7:0] B_PSEC  = 8'h08;
  localparam logic [7:0] B_PMIN  = 8'h10;
  localparam logic [7:0] B_START = 8'h20;
  localparam logic [7:0] B_STOP  = 8'h40;
  localparam logic [7:0] B_CLR   = 8'h80;

  typedef struct {
    logic [7:0]  mask;
    int          reps;
    logic [23:0] digits;
    logic [1:0]  field;
    logic        locked;
    logic        load;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  btn;
  logic [3:0]  min_10s, min_1s, sec_10s, sec_1s, sec100_10s, sec100_1s;
  logic [1:0]  field;
  logic        load;
  logic        locked;
  logic [23:0] digits;

  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[$];
  logic [23:0] exp_q[$];

  assign digits = {min_10s, min_1s, sec_10s, sec_1s, sec100_10s, sec100_1s};

  always #5 clk = ~clk;

  time_entry #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .increment (btn[0]),
    .decrement (btn[1]),
    .place100  (btn[2]),
    .placeSec  (btn[3]),
    .placeMin  (btn[4]),
    .start     (btn[5]),
    .stop      (btn[6]),
    .clear     (btn[7]),
    .min_10s   (min_10s),
    .min_1s    (min_1s),
    .sec_10s   (sec_10s),
    .sec_1s    (sec_1s),
    .sec100_10s(sec100_10s),
    .sec100_1s (sec100_1s),
    .field     (field),
    .load      (load),
    .locked    (locked)
  );

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Clean press: held long enough to debounce, short enough not to repeat, then settled.
  task automatic tap(input logic [7:0] m);
    @(negedge clk);
    btn = m;
    repeat (8) @(negedge clk);
    btn = 8'h00;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    int   exp_cnt;

    reset = 1'b0;
    btn   = 8'h00;

    fork
      begin : load_monitor
        logic        load_prev;
        logic [23:0] e;
        load_prev = 1'b0;
        forever begin
          @(negedge clk);
          if (load) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL load_unexpected digits=%h required=no_load", digits);
            end else begin
              e = exp_q.pop_front();
              if (digits !== e) begin
                failures++;
                $display("FAIL load_digits actual=%h expected=%h", digits, e);
              end
            end
            checks++;
            if (load_prev) begin
              failures++;
              $display("FAIL load_consecutive actual=two_cycles required=one_cycle");
            end
          end
          load_prev = load;
        end
      end
    join_none

    repeat (4) @(negedge clk);
    check("rst_digits", digits, 24'h000000);
    check("rst_field", {22'd0, field}, 24'd0);
    check("rst_load", {23'd0, load}, 24'd0);
    check("rst_locked", {23'd0, locked}, 24'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    vecs.push_back('{B_PMIN,                 1,  24'h000000, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{B_INC,                  1,  24'h010000, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{B_PSEC,                 1,  24'h010000, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_INC,                  30, 24'h013000, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_START,                1,  24'h013000, 2'd1, 1'b1, 1'b1});
    vecs.push_back('{B_INC,                  2,  24'h013000, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{B_PMIN,                 1,  24'h013000, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{B_START,                1,  24'h013000, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{B_STOP,                 1,  24'h013000, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_STOP,                 1,  24'h013000, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_INC,                  1,  24'h013100, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_CLR,                  1,  24'h000000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{B_START,                1,  24'h000000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{B_DEC,                  1,  24'h000099, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{B_INC,                  1,  24'h000000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{B_PMIN,                 1,  24'h000000, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{B_DEC,                  1,  24'h990000, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{B_PSEC,                 1,  24'h990000, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_INC,                  60, 24'h990000, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_DEC,                  1,  24'h995900, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_INC | B_DEC,          1,  24'h995900, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_PMIN | B_PSEC | B_P100, 1, 24'h995900, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{B_PSEC | B_P100,        1,  24'h995900, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{B_CLR | B_START,        1,  24'h000000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{B_INC,                  1,  24'h000001, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{B_START,                1,  24'h000001, 2'd0, 1'b1, 1'b1});
    vecs.push_back('{B_CLR,                  1,  24'h000000, 2'd0, 1'b0, 1'b0});

    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].load) exp_q.push_back(vecs[v].digits);
      for (int r = 0; r < vecs[v].reps; r++) tap(vecs[v].mask);
      check($sformatf("vec%0d_digits", v), digits, vecs[v].digits);
      check($sformatf("vec%0d_field", v), {22'd0, field}, {22'd0, vecs[v].field});
      check($sformatf("vec%0d_locked", v), {23'd0, locked}, {23'd0, vecs[v].locked});
    end

    // Bounce: 2-cycle toggling never satisfies a 4-sample debounce, then a steady hold steps once.
    for (int i = 0; i < 15; i++) begin
      btn = (i % 2 == 0) ? B_INC : 8'h00;
      repeat (2) @(negedge clk);
      if (i == 13) check("bounce_no_step", digits, 24'h000000);
    end
    btn = B_INC;
    repeat (10) @(negedge clk);
    btn = 8'h00;
    repeat (12) @(negedge clk);
    check("bounce_one_step", digits, 24'h000001);

    // Auto-repeat: offsets counted from the first visible step.
    tap(B_CLR);
    @(negedge clk);
    btn = B_INC;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (digits == 24'h000001) found = 1'b1;
    end
    check("repeat_first_step", {23'd0, found}, 24'd1);
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      exp_cnt = 1 + int'(i >= 20) + int'(i >= 25) + int'(i >= 30) + int'(i >= 35);
      check($sformatf("repeat_t%0d", i), digits, 24'(exp_cnt));
      if (i == 31) btn = 8'h00;
    end
    repeat (12) @(negedge clk);
    check("repeat_final", digits, 24'h000005);

    // Reset while locked with increment held.
    exp_q.push_back(24'h000005);
    tap(B_START);
    check("hold_locked", {23'd0, locked}, 24'd1);
    @(negedge clk);
    btn = B_INC;
    repeat (30) @(negedge clk);
    check("hold_frozen", digits, 24'h000005);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_digits", digits, 24'h000000);
    check("midrst_field", {22'd0, field}, 24'd0);
    check("midrst_load", {23'd0, load}, 24'd0);
    check("midrst_locked", {23'd0, locked}, 24'd0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("held_thru_rst_no_step", digits, 24'h000000);
    check("held_thru_rst_unlocked", {23'd0, locked}, 24'd0);
    btn = 8'h00;
    repeat (12) @(negedge clk);
    tap(B_INC);
    check("repress_steps", digits, 24'h000001);

    check("load_queue_empty", 24'(exp_q.size()), 24'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, stable-input cycles needed to accept a button level (10 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 50_000_000, held-button cycles before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10_000_000, cycles between auto-repeat steps.
REQ-004 SHALL have port clk_100MHz  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports increment, decrement  input  1 each  raw asynchronous pushbuttons.
REQ-007 SHALL have ports place100, placeSec, placeMin  input  1 each  raw field-select buttons.
REQ-008 SHALL have ports start, stop, clear  input  1 each  raw pushbuttons.
REQ-009 SHALL have ports min_10s, min_1s, sec_10s, sec_1s, sec100_10s, sec100_1s  output  4 each  BCD entry digits.
REQ-010 SHALL have port field  output  2  selected field: 0 = sec100, 1 = sec, 2 = min.
REQ-011 SHALL have port load  output  1  one-cycle pulse; digits are valid and frozen on that cycle.
REQ-012 SHALL have port locked  output  1  high in HOLD state.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-014 Each debounced input SHALL yield a one-cycle press pulse on its 0->1 edge.
REQ-015 increment/decrement held continuously SHALL emit further steps: first at REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles, stopping on release.
REQ-016 FSM states SHALL be EDIT and HOLD.
REQ-017 In EDIT an increment step SHALL add 1 to the selected field; a decrement step SHALL subtract 1.
REQ-018 Field ranges SHALL be sec100 00-99, sec 00-59 and min 00-99, each wrapping independently (sec 59+1 -> 00, 00-1 -> 59) with no carry or borrow into other fields.
REQ-019 Digits SHALL always be legal BCD.
REQ-020 Field-select press pulses SHALL set field. Simultaneous pulses resolve by priority placeMin > placeSec > place100.
REQ-021 Increment and decrement steps on the same cycle SHALL both be ignored.
REQ-022 A start press in EDIT with any digit nonzero SHALL assert load for exactly one cycle, the cycle after the press pulse, and enter HOLD.
REQ-023 A start press in EDIT with all digits zero SHALL be ignored: no load, state remains EDIT.
REQ-024 In HOLD, increment, decrement, field-select and start SHALL be ignored and the digits SHALL be frozen.
REQ-025 A stop press in HOLD SHALL return to EDIT with the digits retained.
REQ-026 A stop press in EDIT SHALL have no effect.
REQ-027 A clear press in either state SHALL zero all digits, set field=0 and enter EDIT.
REQ-028 Clear on the same cycle as start SHALL win, and no load SHALL occur.
REQ-029 load SHALL never assert in two consecutive cycles.

Reset
REQ-030 While reset=0 at a clock edge, the following SHALL be cleared: all digits 0, field=0, load=0, locked=0, state EDIT, debouncers reporting released, repeat counters 0.
REQ-031 A button held through reset release SHALL produce no press pulse until it is released and pressed again.
REQ-032 Reset asserted mid-repeat or in HOLD SHALL abort immediately, with no load pulse.

Structure
REQ-033 A shared package SHALL hold the field encoding constants (FIELD_SEC100, FIELD_SEC, FIELD_MIN), the FSM state encoding and the per-field maximum values (99, 59, 99).
REQ-034 Synchronizer, debouncer and edge detect SHALL live in one sub-module, btn_debounce, instantiated once per button (8 instances).
REQ-035 BCD add/subtract-with-wrap SHALL be shared logic operating on the selected field only.

Verification
All scenarios run with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20 and REPEAT_PERIOD=5.
REQ-036 Bounce test: increment toggling every 2 cycles for 30 cycles, then held -> exactly one step; sec100 goes 00 -> 01.
REQ-037 Wrap test: placeSec, then 60 increment presses -> sec returns to 00 with min unchanged; one decrement from 00 -> 59.
REQ-038 Auto-repeat test: increment held 40 cycles past debounce -> steps at 0, 20, 25, 30 and 35 cycles; sec100 = 05.
REQ-039 Load test: min=01 and sec=30 set, then start -> single load pulse with digits 0,1,3,0,0,0 and locked=1; increments then ignored; stop -> locked=0 with digits retained.
REQ-040 Zero-start and conflict test: start with all zeros -> no load; clear and start pressed on the same cycle -> digits 0, no load, EDIT.
REQ-041 Reset test: reset=0 during HOLD with increment held -> all outputs 0; no step after reset is released until increment is re-pressed.
